// File: rtl/ddr_cmd_arbiter.sv
// DDR4 command-bus arbiter: shares the single command bus between the ACT,
// PRE and CAS requesters. It enforces tRRD/tCCD spacing and runs periodic
// refresh as PREA -> tRP -> REF -> tRFC, with chaining when refreshes are owed.
module ddr_cmd_arbiter #(
  parameter int unsigned T_RRD        = 4,
  parameter int unsigned T_CCD        = 4,
  parameter int unsigned T_RP         = 13,
  parameter int unsigned T_RFC        = 208,
  parameter int unsigned T_REFI       = 6240,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic        clock_t,
  input  logic        reset_n,
  input  logic        act_req,
  input  logic [20:0] act_addr,
  input  logic        pre_req,
  input  logic [3:0]  pre_addr,
  input  logic        cas_req,
  input  logic        cas_rw,
  input  logic [13:0] cas_addr,
  input  logic        rw_idle,
  output logic        act_gnt,
  output logic        pre_gnt,
  output logic        cas_gnt,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [20:0] cmd_addr,
  output logic        ref_busy,
  output logic        ref_err
);

  localparam int unsigned ADDR_W   = 21;
  localparam int unsigned CMD_W    = 3;
  localparam int unsigned SP_MAX   = (T_RRD > T_CCD) ? T_RRD : T_CCD;
  localparam int unsigned SP_W     = (SP_MAX > 1) ? $clog2(SP_MAX) : 1;
  localparam int unsigned WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int unsigned REFI_W   = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam int unsigned OWED_W   = $clog2(MAX_POSTPONE + 1);

  localparam logic [CMD_W-1:0] CMD_NOP  = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_ACT  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_PRE  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_RD   = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_WR   = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_PREA = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_REF  = CMD_W'(6);

  typedef enum logic [1:0] {
    ST_ARB      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_WAIT_RP  = 2'd2,
    ST_WAIT_RFC = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SP_W-1:0]     rrd_q, rrd_d;
  logic [SP_W-1:0]     ccd_q, ccd_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [REFI_W-1:0]   refi_q, refi_d;
  logic [OWED_W-1:0]   owed_q, owed_d;
  logic                ref_err_d;
  logic                busy_d;

  logic                act_gnt_c, pre_gnt_c, cas_gnt_c;
  logic [CMD_W-1:0]    cmd_c;
  logic [ADDR_W-1:0]   addr_c;
  logic                refi_exp_c, ref_issue_c;

  // State register
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) state_q <= ST_ARB;
    else          state_q <= state_d;
  end

  // Next-state: refresh sequencing and chaining
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:      if (owed_q != '0) state_d = ST_DRAIN;
      ST_DRAIN:    if (rw_idle) state_d = ST_WAIT_RP;
      ST_WAIT_RP:  if (wait_q == '0) state_d = ST_WAIT_RFC;
      ST_WAIT_RFC: if (wait_q == '0) state_d = (owed_q != '0) ? ST_WAIT_RP : ST_ARB;
      default:     state_d = ST_ARB;
    endcase
  end

  // Output decode: fixed-priority grant in ARB, refresh commands otherwise
  always_comb begin
    act_gnt_c = 1'b0;
    pre_gnt_c = 1'b0;
    cas_gnt_c = 1'b0;
    cmd_c     = CMD_NOP;
    addr_c    = '0;
    case (state_q)
      ST_ARB: begin
        if (owed_q == '0) begin
          if (cas_req && (ccd_q == '0)) begin
            cas_gnt_c = 1'b1;
            cmd_c     = cas_rw ? CMD_WR : CMD_RD;
            addr_c    = ADDR_W'(cas_addr);
          end else if (pre_req) begin
            pre_gnt_c = 1'b1;
            cmd_c     = CMD_PRE;
            addr_c    = ADDR_W'(pre_addr);
          end else if (act_req && (rrd_q == '0)) begin
            act_gnt_c = 1'b1;
            cmd_c     = CMD_ACT;
            addr_c    = act_addr;
          end
        end
      end
      ST_DRAIN:    if (rw_idle) cmd_c = CMD_PREA;
      ST_WAIT_RP:  if (wait_q == '0) cmd_c = CMD_REF;
      ST_WAIT_RFC: if ((wait_q == '0) && (owed_q != '0)) cmd_c = CMD_PREA;
      default:     cmd_c = CMD_NOP;
    endcase
  end

  // Counter next values: spacing, refresh wait, refresh interval, owed count
  always_comb begin
    rrd_d = (rrd_q == '0) ? '0 : rrd_q - SP_W'(1);
    if (act_gnt_c) rrd_d = SP_W'(T_RRD - 1);
    ccd_d = (ccd_q == '0) ? '0 : ccd_q - SP_W'(1);
    if (cas_gnt_c) ccd_d = SP_W'(T_CCD - 1);

    wait_d = (wait_q == '0) ? '0 : wait_q - WAIT_W'(1);
    if (cmd_c == CMD_PREA)     wait_d = WAIT_W'(T_RP - 1);
    else if (cmd_c == CMD_REF) wait_d = WAIT_W'(T_RFC - 1);

    refi_exp_c  = (refi_q == '0);
    refi_d      = refi_exp_c ? REFI_W'(T_REFI - 1) : refi_q - REFI_W'(1);
    ref_issue_c = (cmd_c == CMD_REF);

    // Expiry and REF in the same cycle cancel out
    owed_d    = owed_q;
    ref_err_d = ref_err;
    if (refi_exp_c && !ref_issue_c) begin
      if (owed_q == OWED_W'(MAX_POSTPONE)) ref_err_d = 1'b1;
      else                                  owed_d    = owed_q + OWED_W'(1);
    end else if (!refi_exp_c && ref_issue_c) begin
      owed_d = owed_q - OWED_W'(1);
    end

    busy_d = (owed_d != '0) || (state_d != ST_ARB);
  end

  // Datapath and registered bus outputs
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      rrd_q     <= '0;
      ccd_q     <= '0;
      wait_q    <= '0;
      refi_q    <= REFI_W'(T_REFI - 1);
      owed_q    <= '0;
      ref_err   <= 1'b0;
      ref_busy  <= 1'b0;
      act_gnt   <= 1'b0;
      pre_gnt   <= 1'b0;
      cas_gnt   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      cmd_addr  <= '0;
    end else begin
      rrd_q     <= rrd_d;
      ccd_q     <= ccd_d;
      wait_q    <= wait_d;
      refi_q    <= refi_d;
      owed_q    <= owed_d;
      ref_err   <= ref_err_d;
      ref_busy  <= busy_d;
      act_gnt   <= act_gnt_c;
      pre_gnt   <= pre_gnt_c;
      cas_gnt   <= cas_gnt_c;
      cmd_valid <= (cmd_c != CMD_NOP);
      cmd       <= cmd_c;
      cmd_addr  <= addr_c;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: directed scenarios plus random traffic, every
// cycle checked against a timestamp-based model of the command bus rules.
module tb_ddr_cmd_arbiter;

  localparam int T_RRD  = 4;
  localparam int T_CCD  = 4;
  localparam int T_RP   = 13;
  localparam int T_RFC  = 20;
  localparam int T_REFI = 100;
  localparam int MAX_PP = 8;

  localparam int M_ARB   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_REF   = 2;

  logic        clock_t;
  logic        reset_n;
  logic        act_req;
  logic [20:0] act_addr;
  logic        pre_req;
  logic [3:0]  pre_addr;
  logic        cas_req;
  logic        cas_rw;
  logic [13:0] cas_addr;
  logic        rw_idle;
  logic        act_gnt, pre_gnt, cas_gnt, cmd_valid;
  logic [2:0]  cmd;
  logic [20:0] cmd_addr;
  logic        ref_busy, ref_err;

  int total;
  int bad;

  // Model state: edge index since reset, last issue stamps, owed refreshes
  int          e;
  int          last_act, last_cas;
  int          owed;
  bit          err;
  int          mode;
  int          p_edge;
  logic [2:0]  x_cmd;
  logic [20:0] x_addr;
  bit          x_ag, x_pg, x_cg, x_busy;

  ddr_cmd_arbiter #(
    .T_RRD(T_RRD), .T_CCD(T_CCD), .T_RP(T_RP), .T_RFC(T_RFC),
    .T_REFI(T_REFI), .MAX_POSTPONE(MAX_PP)
  ) dut (
    .clock_t(clock_t), .reset_n(reset_n),
    .act_req(act_req), .act_addr(act_addr),
    .pre_req(pre_req), .pre_addr(pre_addr),
    .cas_req(cas_req), .cas_rw(cas_rw), .cas_addr(cas_addr),
    .rw_idle(rw_idle),
    .act_gnt(act_gnt), .pre_gnt(pre_gnt), .cas_gnt(cas_gnt),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_addr(cmd_addr),
    .ref_busy(ref_busy), .ref_err(ref_err)
  );

  initial clock_t = 1'b0;
  always #5 clock_t = ~clock_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    e = 0; last_act = -1000; last_cas = -1000;
    owed = 0; err = 1'b0; mode = M_ARB; p_edge = 0;
    x_cmd = '0; x_addr = '0; x_ag = 0; x_pg = 0; x_cg = 0; x_busy = 0;
  endtask

  // One clock edge of the bus rules, using the inputs present at the edge
  task automatic model_step();
    bit inc, dec;
    e++;
    x_cmd = '0; x_addr = '0; x_ag = 0; x_pg = 0; x_cg = 0;
    inc = ((e % T_REFI) == 0);
    dec = 1'b0;
    case (mode)
      M_ARB: begin
        if (owed > 0) mode = M_DRAIN;
        else if (cas_req && (e - last_cas >= T_CCD)) begin
          x_cg = 1; x_cmd = cas_rw ? 3'd4 : 3'd3; x_addr = 21'(cas_addr); last_cas = e;
        end else if (pre_req) begin
          x_pg = 1; x_cmd = 3'd2; x_addr = 21'(pre_addr);
        end else if (act_req && (e - last_act >= T_RRD)) begin
          x_ag = 1; x_cmd = 3'd1; x_addr = act_addr; last_act = e;
        end
      end
      M_DRAIN: if (rw_idle) begin x_cmd = 3'd5; mode = M_REF; p_edge = e; end
      default: begin
        if (e - p_edge == T_RP) begin
          x_cmd = 3'd6; dec = 1'b1;
        end else if (e - p_edge == T_RP + T_RFC) begin
          if (owed > 0) begin x_cmd = 3'd5; p_edge = e; end
          else mode = M_ARB;
        end
      end
    endcase
    if (inc && !dec) begin
      if (owed == MAX_PP) err = 1'b1;
      else owed++;
    end else if (dec && !inc) begin
      owed--;
    end
    x_busy = (owed != 0) || (mode != M_ARB);
  endtask

  task automatic tick();
    @(posedge clock_t);
    model_step();
    #1;
    check("cmd_valid", 32'(cmd_valid), 32'(x_cmd != 3'd0));
    check("cmd",       32'(cmd),       32'(x_cmd));
    check("cmd_addr",  32'(cmd_addr),  32'(x_addr));
    check("act_gnt",   32'(act_gnt),   32'(x_ag));
    check("pre_gnt",   32'(pre_gnt),   32'(x_pg));
    check("cas_gnt",   32'(cas_gnt),   32'(x_cg));
    check("ref_busy",  32'(ref_busy),  32'(x_busy));
    check("ref_err",   32'(ref_err),   32'(err));
    if (x_ag) act_req = 1'b0;
    if (x_pg) pre_req = 1'b0;
    if (x_cg) cas_req = 1'b0;
  endtask

  task automatic post_act();
    act_req = 1'b1; act_addr = 21'($urandom);
  endtask
  task automatic post_pre();
    pre_req = 1'b1; pre_addr = 4'($urandom);
  endtask
  task automatic post_cas();
    cas_req = 1'b1; cas_rw = 1'($urandom); cas_addr = 14'($urandom);
  endtask

  // Asynchronous reset mid-cycle; released on the following falling edge
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    act_req = 1'b0; pre_req = 1'b0; cas_req = 1'b0;
    model_reset();
    #1;
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd"},   32'(cmd),       32'd0);
    check({tag, "_addr"},  32'(cmd_addr),  32'd0);
    check({tag, "_gnts"},  32'({act_gnt, pre_gnt, cas_gnt}), 32'd0);
    check({tag, "_busy"},  32'(ref_busy),  32'd0);
    check({tag, "_err"},   32'(ref_err),   32'd0);
    @(negedge clock_t);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, preas, refs;
    total = 0; bad = 0;
    reset_n = 1'b1;
    act_req = 0; act_addr = '0; pre_req = 0; pre_addr = '0;
    cas_req = 0; cas_rw = 0; cas_addr = '0; rw_idle = 1'b1;
    #2;
    do_reset("rst0");

    // All three requesters at once: CAS (write), PRE, ACT on consecutive edges
    post_act(); post_pre(); post_cas(); cas_rw = 1'b1;
    tick(); check("prio_1", 32'(cmd), 32'd4);
    tick(); check("prio_2", 32'(cmd), 32'd2);
    tick(); check("prio_3", 32'(cmd), 32'd1);
    repeat (4) tick();

    // ACT held continuously: pulses every T_RRD edges
    for (int i = 1; i <= 13; i++) begin
      if (!act_req) post_act();
      tick();
      check("rrd_space", 32'(act_gnt), 32'((i % T_RRD) == 1));
    end
    repeat (4) tick();

    // CAS blocked by tCCD does not stall PRE
    post_cas(); tick(); check("ccd_c1", 32'(cas_gnt), 32'd1);
    post_cas(); post_pre();
    tick(); check("ccd_pre", 32'(pre_gnt), 32'd1); check("ccd_c2", 32'(cas_gnt), 32'd0);
    tick(); check("ccd_c3", 32'(cas_gnt), 32'd0);
    tick(); check("ccd_c4", 32'(cas_gnt), 32'd0);
    tick(); check("ccd_c5", 32'(cas_gnt), 32'd1);

    // Refresh held off by busy data path, then PREA/REF timing
    do_reset("rst1");
    rw_idle = 1'b0;
    for (int i = 1; i <= 119; i++) begin
      if (i == 105) post_pre();
      tick();
      if (i == 99)  check("busy_pre",  32'(ref_busy), 32'd0);
      if (i == 100) check("busy_post", 32'(ref_busy), 32'd1);
    end
    rw_idle = 1'b1;
    tick(); check("prea_at_120", 32'(cmd), 32'd5);
    repeat (T_RP - 1) tick();
    tick(); check("ref_at_133", 32'(cmd), 32'd6);
    repeat (5) tick();

    // Reset in WAIT_RFC aborts refresh
    do_reset("rst_rfc");
    tick(); check("post_rst_busy", 32'(ref_busy), 32'd0);

    // Postponement saturation, then chained drain
    do_reset("rst2");
    rw_idle = 1'b0;
    repeat (8 * T_REFI + T_REFI - 1) tick();
    check("err_before", 32'(ref_err), 32'd0);
    tick();
    check("err_after", 32'(ref_err), 32'd1);
    rw_idle = 1'b1;
    n = 0; preas = 0; refs = 0;
    do begin
      tick(); n++;
      if (cmd === 3'd5) preas++;
      if (cmd === 3'd6) refs++;
    end while (ref_busy !== 1'b0 && n < 3000);
    check("drain_bound", 32'(n < 3000), 32'd1);
    check("drain_pairs", 32'(preas), 32'(refs));
    check("drain_min8",  32'(refs >= 8), 32'd1);
    post_pre(); tick(); check("reopen_pre", 32'(pre_gnt), 32'd1);

    // Random traffic
    do_reset("rst3");
    for (int i = 0; i < 3000; i++) begin
      rw_idle = ($urandom_range(0, 9) < 7);
      if (!act_req && $urandom_range(0, 2) == 0) post_act();
      if (!pre_req && $urandom_range(0, 3) == 0) post_pre();
      if (!cas_req && $urandom_range(0, 1) == 0) post_cas();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
